mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single downstream memory bus between two requesters: instruction fetch (port I, read-only) and the memory stage (port D, read/write).
- Sits between the pipeline's fetch and memory stages and the cache/memory bus.
- Upstream contract is unchanged: each requester holds its valid until it sees a same-cycle addr_ok & data_ok pulse.
- Latches the granted request, drives it downstream until completion, then routes the response back to the owner.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive D grants while I is pending before I is forced to win the next grant (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  fetch request valid.
- i_addr  in  64  fetch address.
- i_size  in  3  fetch msize encoding.
- i_addr_ok  out  1  fetch accept pulse.
- i_data_ok  out  1  fetch data pulse.
- i_data  out  64  fetch read data.
- d_valid  in  1  memory-stage request valid.
- d_addr  in  64  memory-stage address.
- d_size  in  3  memory-stage msize encoding.
- d_strobe  in  8  byte strobe; nonzero means write.
- d_wdata  in  64  write data, lane-aligned.
- d_addr_ok  out  1  memory-stage accept pulse.
- d_data_ok  out  1  memory-stage data pulse.
- d_data  out  64  memory-stage read data.
- m_valid  out  1  downstream request valid.
- m_addr  out  64  downstream address.
- m_size  out  3  downstream size.
- m_strobe  out  8  downstream byte strobe; 0 = read.
- m_wdata  out  64  downstream write data.
- m_ok  in  1  downstream completion pulse.
- m_rdata  in  64  downstream read data, valid when m_ok.
- owner  out  1  current grant owner; 0 = I, 1 = D; meaningful only while m_valid.

Behaviour:
- FSM states: IDLE, BUSY.
- Reset (synchronous):
  - state = IDLE, starvation counter = 0.
  - Latched request fields = 0; m_valid = 0, owner = 0.
  - All upstream ok outputs = 0.
  - Applies mid-transaction: the in-flight request is dropped, m_valid falls on the next cycle, no ok pulse is issued.
- IDLE:
  - If neither valid is asserted: stay in IDLE.
  - Else select a winner and register its fields into the latch; state becomes BUSY at the next edge.
  - m_valid is registered, so it rises one cycle after the request is first seen.
  - For an I grant: m_strobe = 0 and m_wdata = 0.
- Priority:
  - D wins over I by default.
  - If both are valid and the starvation counter equals STARVE_LIMIT, I wins.
- Starvation counter:
  - Increments on each D grant made while i_valid = 1, saturating at STARVE_LIMIT.
  - Clears on any I grant, or on a D grant made while i_valid = 0.
- BUSY:
  - m_* outputs hold the latched values; they are stable for the whole transaction regardless of upstream inputs.
  - When m_ok = 1: the owner's addr_ok and data_ok are asserted combinationally in that same cycle, and its data output = m_rdata; state returns to IDLE at the next edge.
  - The non-owner's ok outputs stay 0 at all times.
- Gap cycle: after completion, one IDLE cycle always precedes the next grant. There are no back-to-back grants, so a requester that just received ok has time to drop its valid.
- Owner drops valid while BUSY: the transaction still completes, and the ok pulse is still issued.
- m_ok received while IDLE: ignored, and no upstream pulse is issued.
- i_data and d_data outputs: equal m_rdata during the owner's ok cycle, 0 otherwise.

Optional Feature:
- Macro: MEM_BUS_ARB_PERF_EN.
- When defined, three extra outputs are added:
  - perf_i_grants, 32 bit: counts I grants.
  - perf_d_grants, 32 bit: counts D grants.
  - perf_i_wait, 32 bit: counts cycles with i_valid = 1 and no I transaction in progress (not in BUSY with owner = I).
- All three counters are cleared by reset and wrap at 2^32.
- When undefined: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Single fetch: i_valid at cycle 0, addr 0x8000_0000, m_ok at cycle 3 with m_rdata = 0x1234 -> m_valid cycles 1–3; i_addr_ok = i_data_ok = 1 only in cycle 3; i_data = 0x1234; state back to IDLE in cycle 4.
- Single store: d_valid with addr 0x10, strobe 0x0F, wdata 0xAABBCCDD -> m_strobe = 0x0F and m_wdata = 0xAABBCCDD held stable until m_ok; d ok pulse in the m_ok cycle; i ok outputs remain 0 throughout.
- Contention: both valid and continuously re-requesting, STARVE_LIMIT = 4, m_ok 2 cycles after each m_valid -> owner sequence D,D,D,D,I,D,D,D,D,I.
- Reset mid-op: BUSY with owner D, reset asserted for 1 cycle, then m_ok pulses -> m_valid = 0 after reset; no d or i ok pulse issued.
- Stray/early m_ok: m_ok in IDLE -> no outputs change. Requester drops valid while BUSY, then m_ok -> ok pulse still issued; next cycle is IDLE with no new grant.
- With MEM_BUS_ARB_PERF_EN defined: run the contention test for 10 grants -> perf_d_grants = 8, perf_i_grants = 2, and perf_i_wait equals the count of cycles with i_valid = 1 outside I's BUSY periods, checked against a scoreboard.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory bus between fetch (I) and mem stage (D).
// Define MEM_BUS_ARB_PERF_EN to add grant and fetch-wait performance counters.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [63:0] i_addr,
   input  logic [2:0]  i_size,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [63:0] i_data,
   input  logic        d_valid,
   input  logic [63:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic [7:0]  d_strobe,
   input  logic [63:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [63:0] d_data,
   output logic        m_valid,
   output logic [63:0] m_addr,
   output logic [2:0]  m_size,
   output logic [7:0]  m_strobe,
   output logic [63:0] m_wdata,
   input  logic        m_ok,
   input  logic [63:0] m_rdata,
   output logic        owner
`ifdef MEM_BUS_ARB_PERF_EN
   ,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_i_wait
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   state_t     state_n;
   logic [3:0] starve;
   logic [3:0] starve_n;
   logic       grant;
   logic       grant_i;
   logic       done;
   logic       ok_now;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         starve <= '0;
      end else begin
         state  <= state_n;
         starve <= starve_n;
      end
   end

   always_comb begin
      state_n  = state;
      starve_n = starve;
      grant    = 1'b0;
      grant_i  = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_valid || d_valid) begin
               grant   = 1'b1;
               grant_i = !d_valid || (i_valid && starve == LIMIT);
               state_n = BUSY;
               // Only D wins taken over a waiting fetch count toward starvation
               if (grant_i || !i_valid) begin
                  starve_n = '0;
               end else if (starve != LIMIT) begin
                  starve_n = starve + 4'd1;
               end
            end
         end
         BUSY: begin
            if (m_ok) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid  <= 1'b0;
         owner    <= 1'b0;
         m_addr   <= '0;
         m_size   <= '0;
         m_strobe <= '0;
         m_wdata  <= '0;
      end else if (grant) begin
         m_valid  <= 1'b1;
         owner    <= !grant_i;
         m_addr   <= grant_i ? i_addr : d_addr;
         m_size   <= grant_i ? i_size : d_size;
         m_strobe <= grant_i ? 8'h00 : d_strobe;
         m_wdata  <= grant_i ? 64'h0 : d_wdata;
      end else if (done) begin
         m_valid  <= 1'b0;
      end
   end

   assign ok_now    = (state == BUSY) && m_ok && !reset;
   assign i_addr_ok = ok_now && !owner;
   assign i_data_ok = ok_now && !owner;
   assign i_data    = (ok_now && !owner) ? m_rdata : 64'h0;
   assign d_addr_ok = ok_now && owner;
   assign d_data_ok = ok_now && owner;
   assign d_data    = (ok_now && owner) ? m_rdata : 64'h0;

`ifdef MEM_BUS_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_i_grants <= '0;
         perf_d_grants <= '0;
         perf_i_wait   <= '0;
      end else begin
         if (grant && grant_i) begin
            perf_i_grants <= perf_i_grants + 32'd1;
         end
         if (grant && !grant_i) begin
            perf_d_grants <= perf_d_grants + 32'd1;
         end
         if (i_valid && !(state == BUSY && !owner)) begin
            perf_i_wait <= perf_i_wait + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter
// against a transaction-level reference model.
module tb_mem_bus_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [63:0] i_addr;
   logic [2:0]  i_size;
   logic        i_addr_ok;
   logic        i_data_ok;
   logic [63:0] i_data;
   logic        d_valid;
   logic [63:0] d_addr;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;
   logic [63:0] d_wdata;
   logic        d_addr_ok;
   logic        d_data_ok;
   logic [63:0] d_data;
   logic        m_valid;
   logic [63:0] m_addr;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;
   logic [63:0] m_wdata;
   logic        m_ok;
   logic [63:0] m_rdata;
   logic        owner;
`ifdef MEM_BUS_ARB_PERF_EN
   logic [31:0] perf_i_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_i_wait;
`endif

   always #5 clk = ~clk;

   mem_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_size(i_size),
      .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
      .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size),
      .d_strobe(d_strobe), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
      .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size),
      .m_strobe(m_strobe), .m_wdata(m_wdata),
      .m_ok(m_ok), .m_rdata(m_rdata), .owner(owner)
`ifdef MEM_BUS_ARB_PERF_EN
      ,
      .perf_i_grants(perf_i_grants),
      .perf_d_grants(perf_d_grants),
      .perf_i_wait(perf_i_wait)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one outstanding transaction at a time
   bit          mbusy;
   bit          mown;
   logic [63:0] ma;
   logic [2:0]  ms;
   logic [7:0]  mst;
   logic [63:0] mwd;
   int          streak;
   int          age;
   int          cnt_i;
   int          cnt_d;
   int          cnt_w;
   bit          last_iok;
   bit          last_dok;
   logic        prev_mv;
   bit          dut_owner_q[$];
   bit          exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mbusy  = 0;
      mown   = 0;
      ma     = '0;
      ms     = '0;
      mst    = '0;
      mwd    = '0;
      streak = 0;
      age    = 0;
      cnt_i  = 0;
      cnt_d  = 0;
      cnt_w  = 0;
   endtask

   task automatic check_outputs();
      bit eiok;
      bit edok;
      eiok = mbusy && m_ok && !mown && !reset;
      edok = mbusy && m_ok && mown && !reset;
      chk("m_valid", m_valid, mbusy);
      if (mbusy) begin
         chk("owner", owner, mown);
         chk("m_addr", m_addr, ma);
         chk("m_size", m_size, ms);
         chk("m_strobe", m_strobe, mst);
         chk("m_wdata", m_wdata, mwd);
      end
      chk("i_addr_ok", i_addr_ok, eiok);
      chk("i_data_ok", i_data_ok, eiok);
      chk("i_data", i_data, eiok ? m_rdata : 64'h0);
      chk("d_addr_ok", d_addr_ok, edok);
      chk("d_data_ok", d_data_ok, edok);
      chk("d_data", d_data, edok ? m_rdata : 64'h0);
`ifdef MEM_BUS_ARB_PERF_EN
      chk("perf_i_grants", perf_i_grants, cnt_i);
      chk("perf_d_grants", perf_d_grants, cnt_d);
      chk("perf_i_wait", perf_i_wait, cnt_w);
`endif
      last_iok = eiok;
      last_dok = edok;
   endtask

   task automatic model_update();
      bit pick_i;
      if (reset) begin
         model_reset();
      end else begin
         if (i_valid && !(mbusy && !mown)) cnt_w++;
         if (mbusy) begin
            if (m_ok) mbusy = 0;
            else age++;
         end else if (i_valid || d_valid) begin
            pick_i = !d_valid || (i_valid && streak == LIM);
            if (pick_i) begin
               mown = 0; ma = i_addr; ms = i_size;
               mst = 8'h00; mwd = 64'h0;
               streak = 0;
               cnt_i++;
            end else begin
               mown = 1; ma = d_addr; ms = d_size;
               mst = d_strobe; mwd = d_wdata;
               streak = i_valid ? ((streak < LIM) ? streak + 1 : LIM) : 0;
               cnt_d++;
            end
            mbusy = 1;
            age = 0;
         end
      end
   endtask

   task automatic tick();
      #1;
      check_outputs();
      if (m_valid === 1'b1 && prev_mv !== 1'b1) dut_owner_q.push_back(owner);
      prev_mv = m_valid;
      model_update();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; i_valid = 0; i_addr = '0; i_size = '0;
      d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
      m_ok = 0; m_rdata = '0; prev_mv = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      #1;
      chk("rst_owner", owner, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      tick();
      reset = 0;
      tick();

      // single fetch
      i_valid = 1; i_addr = 64'h8000_0000; i_size = 3'd3;
      #1 chk("fetch_c0_mvalid", m_valid, 1'b0);
      tick();
      #1 chk("fetch_c1_mvalid", m_valid, 1'b1);
      tick();
      tick();
      m_ok = 1; m_rdata = 64'h1234;
      #1;
      chk("fetch_iaddr_ok", i_addr_ok, 1'b1);
      chk("fetch_idata", i_data, 64'h1234);
      chk("fetch_m_strobe", m_strobe, 8'h00);
      tick();
      m_ok = 0; i_valid = 0;
      #1 chk("fetch_c4_idle", m_valid, 1'b0);
      tick();

      // single store with upstream fields changing while busy
      d_valid = 1; d_addr = 64'h10; d_size = 3'd2;
      d_strobe = 8'h0F; d_wdata = 64'hAABB_CCDD;
      tick();
      d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      tick();
      #1;
      chk("store_strobe", m_strobe, 8'h0F);
      chk("store_wdata", m_wdata, 64'hAABB_CCDD);
      chk("store_addr", m_addr, 64'h10);
      tick();
      m_ok = 1; m_rdata = 64'h55;
      #1;
      chk("store_dok", d_addr_ok, 1'b1);
      chk("store_iok", i_addr_ok, 1'b0);
      tick();
      m_ok = 0; d_valid = 0;
      tick();

      // contention with continuous re-requests
      reset = 1;
      tick();
      reset = 0;
      dut_owner_q.delete();
      i_valid = 1; i_addr = {$urandom, $urandom}; i_size = 3'd2;
      d_valid = 1; d_addr = {$urandom, $urandom}; d_size = 3'd3;
      d_strobe = 8'hF0; d_wdata = {$urandom, $urandom};
      for (int c = 0; c < 300 && dut_owner_q.size() < 10; c++) begin
         m_ok = mbusy && (age == 2);
         m_rdata = {$urandom, $urandom};
         tick();
      end
      chk("cont_grants", dut_owner_q.size(), 10);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("owner_seq%0d", k),
             (k < dut_owner_q.size()) ? 64'(dut_owner_q[k]) : 'x,
             64'(exp_seq[k]));
      end
`ifdef MEM_BUS_ARB_PERF_EN
      #1;
      chk("cont_perf_d", perf_d_grants, 32'd8);
      chk("cont_perf_i", perf_i_grants, 32'd2);
      chk("cont_perf_wait", perf_i_wait, cnt_w);
`endif
      i_valid = 0; d_valid = 0;
      for (int c = 0; c < 10 && mbusy; c++) begin
         m_ok = 1;
         tick();
      end
      m_ok = 0;
      tick();

      // reset during a D transaction
      d_valid = 1; d_addr = 64'h40; d_strobe = 8'h00;
      tick();
      tick();
      reset = 1; d_valid = 0;
      tick();
      reset = 0;
      #1 chk("midrst_mvalid", m_valid, 1'b0);
      m_ok = 1; m_rdata = 64'h77;
      #1;
      chk("midrst_dok", d_addr_ok, 1'b0);
      chk("midrst_iok", i_addr_ok, 1'b0);
      tick();
      m_ok = 0;

      // stray m_ok while idle
      m_ok = 1; m_rdata = 64'hDEAD;
      #1;
      chk("stray_idata", i_data, 64'h0);
      chk("stray_ddata", d_data, 64'h0);
      tick();
      m_ok = 0;

      // owner drops valid while busy
      i_valid = 1; i_addr = 64'h2000; i_size = 3'd3;
      tick();
      i_valid = 0;
      tick();
      m_ok = 1; m_rdata = 64'hBEEF;
      #1 chk("drop_iok", i_data_ok, 1'b1);
      tick();
      m_ok = 0;
      #1 chk("drop_no_regrant", m_valid, 1'b0);
      tick();
      tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (i_valid && (last_iok || $urandom % 25 == 0)) begin
            i_valid = 0;
         end else if (!i_valid && $urandom % 3 == 0) begin
            i_valid = 1;
            i_addr = {$urandom, $urandom};
            i_size = 3'($urandom);
         end
         if (d_valid && (last_dok || $urandom % 25 == 0)) begin
            d_valid = 0;
         end else if (!d_valid && $urandom % 3 == 0) begin
            d_valid = 1;
            d_addr = {$urandom, $urandom};
            d_size = 3'($urandom);
            d_strobe = ($urandom % 2 == 0) ? 8'($urandom) : 8'h00;
            d_wdata = {$urandom, $urandom};
         end
         m_ok = mbusy ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
         m_rdata = {$urandom, $urandom};
         reset = ($urandom % 100 == 0);
         if (reset) m_ok = 0;
         tick();
      end
      reset = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
